// File: rtl/temporizador_pkg.sv
// Shared types for the step timer: state encoding and default bus width.
package temporizador_pkg;

   localparam int LARGURA_PADRAO = 16;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      CONTANDO  = 2'd1,
      PAUSADO   = 2'd2,
      CONCLUIDO = 2'd3
   } estado_t;

endpackage

// File: rtl/sincroniza_borda.sv
// Synchronises an asynchronous level into CLOCKIN and emits a one-cycle pulse per rising edge.
// Latency: pulse is high in the cycle after the SYNC_ESTAGIOS-th edge that samples the input high.
module sincroniza_borda #(
   parameter int SYNC_ESTAGIOS = 2
) (
   input  logic CLOCKIN,
   input  logic RESET,
   input  logic TICKIN,
   output logic tick
);

   logic [SYNC_ESTAGIOS-1:0] r_sync;
   logic                     r_borda;

   always_ff @(posedge CLOCKIN or negedge RESET) begin
      if (!RESET) begin
         r_sync  <= '0;
         r_borda <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_ESTAGIOS-2:0], TICKIN};
         r_borda <= r_sync[SYNC_ESTAGIOS-1];
      end
   end

   assign tick = r_sync[SYNC_ESTAGIOS-1] & ~r_borda;

endmodule

// File: rtl/temporizador_etapa.sv
// Programmable step timer counting rising edges of the divided clock, with start/pause/cancel.
// Optional TEMPORIZADOR_AUTO_RECARGA_EN: reload DURACAO on completion and keep counting.
module temporizador_etapa
   import temporizador_pkg::*;
#(
   parameter int LARGURA       = LARGURA_PADRAO,
   parameter int SYNC_ESTAGIOS = 2
) (
   input  logic               CLOCKIN,
   input  logic               RESET,
   input  logic               TICKIN,
   input  logic               INICIAR,
   input  logic [LARGURA-1:0] DURACAO,
   input  logic               PAUSA,
   input  logic               CANCELA,
   output logic [LARGURA-1:0] RESTANTE,
   output logic               ATIVO,
   output logic               PRONTO,
   output logic               FIM
);

   estado_t              r_estado;
   logic [LARGURA-1:0]   r_restante;
   logic                 r_fim;
   estado_t              w_estado_prox;
   logic [LARGURA-1:0]   w_restante_prox;
   logic                 w_fim_prox;
   logic                 w_tick;

   sincroniza_borda #(
      .SYNC_ESTAGIOS(SYNC_ESTAGIOS)
   ) u_sincroniza_borda (
      .CLOCKIN(CLOCKIN),
      .RESET  (RESET),
      .TICKIN (TICKIN),
      .tick   (w_tick)
   );

   always_ff @(posedge CLOCKIN or negedge RESET) begin
      if (!RESET) begin
         r_estado   <= OCIOSO;
         r_restante <= '0;
         r_fim      <= 1'b0;
      end else begin
         r_estado   <= w_estado_prox;
         r_restante <= w_restante_prox;
         r_fim      <= w_fim_prox;
      end
   end

   // Priority: CANCELA > INICIAR > PAUSA > tick; INICIAR only acts when not counting.
   always_comb begin
      w_estado_prox   = r_estado;
      w_restante_prox = r_restante;
      w_fim_prox      = 1'b0;
      if (CANCELA) begin
         w_estado_prox   = OCIOSO;
         w_restante_prox = '0;
      end else begin
         case (r_estado)
            OCIOSO, CONCLUIDO: begin
               if (INICIAR) begin
                  if (DURACAO != '0) begin
                     w_estado_prox   = CONTANDO;
                     w_restante_prox = DURACAO;
                  end else begin
                     w_estado_prox   = CONCLUIDO;
                     w_restante_prox = '0;
                     w_fim_prox      = 1'b1;
                  end
               end
            end
            CONTANDO: begin
               if (PAUSA) begin
                  w_estado_prox = PAUSADO;
               end else if (w_tick) begin
                  if (r_restante > LARGURA'(1)) begin
                     w_restante_prox = r_restante - LARGURA'(1);
                  end else begin
                     w_fim_prox = 1'b1;
`ifdef TEMPORIZADOR_AUTO_RECARGA_EN
                     // A zero reload would loop forever, so it ends in CONCLUIDO instead.
                     if (DURACAO != '0) begin
                        w_estado_prox   = CONTANDO;
                        w_restante_prox = DURACAO;
                     end else begin
                        w_estado_prox   = CONCLUIDO;
                        w_restante_prox = '0;
                     end
`else
                     w_estado_prox   = CONCLUIDO;
                     w_restante_prox = '0;
`endif
                  end
               end
            end
            PAUSADO: begin
               if (!PAUSA) begin
                  w_estado_prox = CONTANDO;
               end
            end
            default: begin
               w_estado_prox = OCIOSO;
            end
         endcase
      end
   end

   always_comb begin
      ATIVO    = (r_estado == CONTANDO) || (r_estado == PAUSADO);
      PRONTO   = (r_estado == CONCLUIDO);
      RESTANTE = r_restante;
      FIM      = r_fim;
   end

endmodule

// File: tb/tb_temporizador_etapa.sv
// Directed bench for temporizador_etapa: a cycle-level behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_temporizador_etapa;

   localparam int W = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic          CLOCKIN = 1'b0;
   logic          RESET   = 1'b0;
   logic          TICKIN  = 1'b0;
   logic          INICIAR = 1'b0;
   logic [W-1:0]  DURACAO = '0;
   logic          PAUSA   = 1'b0;
   logic          CANCELA = 1'b0;
   logic [W-1:0]  RESTANTE;
   logic          ATIVO;
   logic          PRONTO;
   logic          FIM;

   int n_checks = 0;
   int n_errors = 0;
   int m_est    = M_IDLE;
   int m_rest   = 0;
   bit m_fim    = 1'b0;
   bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
   int fim_cnt  = 0;
   bit pronto_seen = 1'b0;

   temporizador_etapa #(.LARGURA(W), .SYNC_ESTAGIOS(2)) dut (
      .CLOCKIN (CLOCKIN),
      .RESET   (RESET),
      .TICKIN  (TICKIN),
      .INICIAR (INICIAR),
      .DURACAO (DURACAO),
      .PAUSA   (PAUSA),
      .CANCELA (CANCELA),
      .RESTANTE(RESTANTE),
      .ATIVO   (ATIVO),
      .PRONTO  (PRONTO),
      .FIM     (FIM)
   );

   always #5 CLOCKIN = ~CLOCKIN;

   task automatic model_reset();
      m_est = M_IDLE; m_rest = 0; m_fim = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
   endtask

   // One clock edge of the timer; a TICKIN rise counts two edges after it is first sampled.
   task automatic model_update();
      bit tk;
      if (!RESET) begin
         model_reset();
         return;
      end
      tk = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = TICKIN;
      m_fim = 1'b0;
      if (CANCELA) begin
         m_est = M_IDLE; m_rest = 0;
      end else if (INICIAR && (m_est == M_IDLE || m_est == M_DONE)) begin
         if (DURACAO > 0) begin
            m_est = M_RUN; m_rest = int'(DURACAO);
         end else begin
            m_est = M_DONE; m_rest = 0; m_fim = 1'b1;
         end
      end else if (m_est == M_RUN) begin
         if (PAUSA) m_est = M_PAUSE;
         else if (tk) begin
            m_rest = m_rest - 1;
            if (m_rest == 0) begin
               m_fim = 1'b1;
`ifdef TEMPORIZADOR_AUTO_RECARGA_EN
               if (DURACAO > 0) m_rest = int'(DURACAO);
               else m_est = M_DONE;
`else
               m_est = M_DONE;
`endif
            end
         end
      end else if (m_est == M_PAUSE && !PAUSA) begin
         m_est = M_RUN;
      end
   endtask

   always @(negedge CLOCKIN) begin
      n_checks = n_checks + 4;
      if (int'(RESTANTE) != m_rest) begin
         n_errors++; $display("FAIL model_restante got %0d want %0d at %0t", RESTANTE, m_rest, $time);
      end
      if (ATIVO !== (m_est == M_RUN || m_est == M_PAUSE)) begin
         n_errors++; $display("FAIL model_ativo got %b want %b at %0t", ATIVO, (m_est == M_RUN || m_est == M_PAUSE), $time);
      end
      if (PRONTO !== (m_est == M_DONE)) begin
         n_errors++; $display("FAIL model_pronto got %b want %b at %0t", PRONTO, (m_est == M_DONE), $time);
      end
      if (FIM !== m_fim) begin
         n_errors++; $display("FAIL model_fim got %b want %b at %0t", FIM, m_fim, $time);
      end
      if (FIM === 1'b1) fim_cnt++;
      if (PRONTO === 1'b1) pronto_seen = 1'b1;
   end

   task automatic chk(input string nome, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s got %0d want %0d", nome, got, want);
      end
   endtask

   task automatic ciclo(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCKIN);
         model_update();
         @(negedge CLOCKIN);
         #1;
      end
   endtask

   task automatic tick_ev();
      TICKIN = 1'b1; ciclo(3);
      TICKIN = 1'b0; ciclo(5);
   endtask

   task automatic iniciar(input int d);
      DURACAO = W'(d); INICIAR = 1'b1; ciclo(1); INICIAR = 1'b0;
   endtask

   initial begin
      int f0;
      model_reset();
      // Reset held while TICKIN toggles
      for (int i = 0; i < 5; i++) begin
         TICKIN = ~TICKIN; ciclo(1);
      end
      chk("reset_restante", int'(RESTANTE), 0);
      chk("reset_ativo", int'(ATIVO), 0);
      chk("reset_pronto", int'(PRONTO), 0);
      chk("reset_fim_cnt", fim_cnt, 0);
      TICKIN = 1'b0; RESET = 1'b1; ciclo(4);

`ifdef TEMPORIZADOR_AUTO_RECARGA_EN
      iniciar(2);
      f0 = fim_cnt;
      for (int i = 0; i < 6; i++) tick_ev();
      chk("auto_fim_pulses", fim_cnt - f0, 3);
      chk("auto_pronto_seen", int'(pronto_seen), 0);
      chk("auto_ativo", int'(ATIVO), 1);
      chk("auto_restante", int'(RESTANTE), 2);
      CANCELA = 1'b1; ciclo(1); CANCELA = 1'b0;
      chk("auto_cancel_ativo", int'(ATIVO), 0);
`else
      // DURACAO=3: each step lands 3 edges after the TICKIN rise
      iniciar(3);
      chk("d3_load", int'(RESTANTE), 3);
      chk("d3_ativo", int'(ATIVO), 1);
      f0 = fim_cnt;
      TICKIN = 1'b1; ciclo(2);
      chk("d3_before_edge3", int'(RESTANTE), 3);
      ciclo(1);
      chk("d3_step1", int'(RESTANTE), 2);
      TICKIN = 1'b0; ciclo(5);
      tick_ev();
      chk("d3_step2", int'(RESTANTE), 1);
      TICKIN = 1'b1; ciclo(3);
      chk("d3_done_rest", int'(RESTANTE), 0);
      chk("d3_done_fim", int'(FIM), 1);
      chk("d3_done_pronto", int'(PRONTO), 1);
      chk("d3_done_ativo", int'(ATIVO), 0);
      TICKIN = 1'b0; ciclo(1);
      chk("d3_fim_one_cycle", int'(FIM), 0);
      ciclo(4);
      chk("d3_fim_cnt", fim_cnt - f0, 1);

      // Pause across two ticks
      iniciar(5);
      tick_ev();
      chk("pause_first", int'(RESTANTE), 4);
      PAUSA = 1'b1; ciclo(1);
      tick_ev(); tick_ev();
      chk("pause_hold", int'(RESTANTE), 4);
      PAUSA = 1'b0; ciclo(2);
      f0 = fim_cnt;
      tick_ev(); tick_ev(); tick_ev();
      chk("pause_after3", int'(RESTANTE), 1);
      chk("pause_no_fim_yet", fim_cnt - f0, 0);
      tick_ev();
      chk("pause_fim", fim_cnt - f0, 1);
      chk("pause_pronto", int'(PRONTO), 1);

      // Zero duration
      CANCELA = 1'b1; ciclo(1); CANCELA = 1'b0;
      f0 = fim_cnt;
      iniciar(0);
      chk("d0_pronto", int'(PRONTO), 1);
      chk("d0_fim", int'(FIM), 1);
      chk("d0_rest", int'(RESTANTE), 0);
      ciclo(3);
      chk("d0_fim_cnt", fim_cnt - f0, 1);

      // Cancel colliding with the final tick
      iniciar(1);
      f0 = fim_cnt;
      TICKIN = 1'b1; ciclo(2);
      CANCELA = 1'b1; ciclo(1); CANCELA = 1'b0;
      chk("cancel_rest", int'(RESTANTE), 0);
      chk("cancel_ativo", int'(ATIVO), 0);
      chk("cancel_pronto", int'(PRONTO), 0);
      TICKIN = 1'b0; ciclo(5);
      chk("cancel_no_fim", fim_cnt - f0, 0);

      // Start request ignored while counting
      iniciar(7);
      iniciar(2);
      chk("restart_ignored", int'(RESTANTE), 7);
      tick_ev();
      chk("restart_counts_on", int'(RESTANTE), 6);
`endif
      ciclo(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/temporizador_etapa.md
Name: temporizador_etapa

Overview:
- Programmable step timer that sits directly downstream of the frequency divider and consumes its 5 Hz square wave (one full period = 200 ms).
- Treats the divided clock as data, never as a clock: synchronises it into the CLOCKIN domain and turns each rising edge into a one-cycle tick.
- Counts a loaded number of ticks with start/pause/cancel control and reports completion to the process controller (fermentation/bottling step durations).

Parameters:
- LARGURA, 16, width of the duration and remaining-count buses.
- SYNC_ESTAGIOS, 2, number of synchroniser flip-flops on TICKIN (legal values 2 or 3).

Ports:
- CLOCKIN  input  1  system clock (100 MHz).
- RESET  input  1  asynchronous, active-low reset.
- TICKIN  input  1  divided clock from the divider (5 Hz square wave), asynchronous to CLOCKIN logic.
- INICIAR  input  1  start request, level sampled each cycle.
- DURACAO  input  LARGURA  number of ticks to count; captured when a start is accepted.
- PAUSA  input  1  freeze the count while high.
- CANCELA  input  1  abort and return to idle.
- RESTANTE  output  LARGURA  ticks still to elapse.
- ATIVO  output  1  high in CONTANDO or PAUSADO.
- PRONTO  output  1  high in CONCLUIDO.
- FIM  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RESET=0, asynchronous): state OCIOSO; RESTANTE=0, ATIVO=0, PRONTO=0, FIM=0; synchroniser and edge registers cleared to 0.
- Tick generation: TICKIN passes through SYNC_ESTAGIOS flip-flops, then one edge register.
  - tick = sync_out & ~edge_reg.
  - With SYNC_ESTAGIOS=2, tick is high during the cycle after the 2nd CLOCKIN rising edge that samples TICKIN=1; the counter updates on the 3rd edge.
  - Exactly one tick per TICKIN rising edge; falling edges produce none.
- States: OCIOSO, CONTANDO, PAUSADO, CONCLUIDO. Priority each cycle: CANCELA > INICIAR > PAUSA > tick.
- OCIOSO:
  - INICIAR=1 and DURACAO>0: RESTANTE<=DURACAO, go to CONTANDO.
  - INICIAR=1 and DURACAO=0: go straight to CONCLUIDO with FIM pulse, RESTANTE stays 0.
- CONTANDO:
  - tick and RESTANTE>1: RESTANTE decrements by 1.
  - tick and RESTANTE==1: RESTANTE<=0, go to CONCLUIDO, FIM=1 next cycle only.
  - PAUSA=1: go to PAUSADO; a tick in that same cycle is discarded.
  - INICIAR while counting is ignored (no restart).
- PAUSADO:
  - RESTANTE holds; ticks are discarded.
  - PAUSA=0: return to CONTANDO. The next tick is counted, with no catch-up for ticks missed while paused.
- CONCLUIDO:
  - PRONTO=1; stays here until INICIAR (reloads as in OCIOSO) or CANCELA (goes to OCIOSO).
- CANCELA in any state: go to OCIOSO and clear RESTANTE to 0 next cycle; no FIM pulse.
- Output timing: all outputs are registered; ATIVO and PRONTO are decoded from the registered state.
- Arithmetic: unsigned. RESTANTE never decrements below 0 and never wraps.
- Reset mid-count: immediate return to reset values; in-flight ticks are lost.

Optional Feature:
- Macro: TEMPORIZADOR_AUTO_RECARGA_EN.
- Defined: on completion, DURACAO is recaptured and the block goes straight back to CONTANDO instead of CONCLUIDO.
  - FIM still pulses once per period; PRONTO stays 0.
  - DURACAO=0 in auto-reload goes to CONCLUIDO, so there is no zero-length loop.
  - CANCELA stops the loop.
- Undefined: behaviour exactly as above, with no reload logic synthesised.

Decomposition:
- Package temporizador_pkg: state enum (OCIOSO=2'd0, CONTANDO=2'd1, PAUSADO=2'd2, CONCLUIDO=2'd3) and default LARGURA.
- Sub-module sincroniza_borda (parameter SYNC_ESTAGIOS; ports CLOCKIN, RESET, TICKIN -> tick) holds the synchroniser plus rising-edge detector. It is reusable for push-button inputs.

Test Plan:
- Reset with TICKIN toggling: RESET low for 5 cycles -> all outputs 0, no FIM.
- DURACAO=3, INICIAR pulse, 3 TICKIN rising edges -> RESTANTE 3->2->1->0, each step 3 cycles after its edge. FIM high exactly 1 cycle, PRONTO=1, ATIVO=0.
- DURACAO=5, PAUSA high across 2 ticks after the first decrement -> RESTANTE holds 4. After release, 4 more ticks are needed before FIM.
- DURACAO=0, INICIAR -> CONCLUIDO next cycle, single FIM pulse, RESTANTE=0.
- CANCELA asserted together with a tick at RESTANTE=1 -> OCIOSO, RESTANTE=0, no FIM. INICIAR during CONTANDO (RESTANTE=7) -> no reload, count unaffected.
- With TEMPORIZADOR_AUTO_RECARGA_EN, DURACAO=2, 6 ticks -> 3 FIM pulses, PRONTO never high.
